// File: rtl/caf_freq_max_select_if.sv
// rtl/caf_freq_max_select_if.sv - per-bin result input and sweep result output bundle for caf_freq_max_select
interface caf_freq_max_select_if #(
    parameter int MAX_BITS        = 4,
    parameter int INDEX_BITS      = 4,
    parameter int FREQ_INDEX_BITS = 3
);
    // Per-bin result from arg_max
    logic                       m_axis_tvalid;
    logic [MAX_BITS-1:0]        in_max;
    logic [INDEX_BITS-1:0]      in_index;
    logic                       s_axis_tready;

    // Detection threshold, sampled when a sweep completes
    logic [MAX_BITS-1:0]        threshold;

    // Sweep result toward the CAF output/control logic
    logic                       s_axis_tvalid;
    logic                       m_axis_tready;
    logic [MAX_BITS-1:0]        out_max;
    logic [INDEX_BITS-1:0]      time_index;
    logic [FREQ_INDEX_BITS-1:0] freq_index;
    logic                       detect;

    // Environment side: supplies bin results, threshold and downstream ready
    modport master (
        output m_axis_tvalid, in_max, in_index, threshold, m_axis_tready,
        input  s_axis_tready, s_axis_tvalid, out_max, time_index, freq_index, detect
    );

    // Block side
    modport slave (
        input  m_axis_tvalid, in_max, in_index, threshold, m_axis_tready,
        output s_axis_tready, s_axis_tvalid, out_max, time_index, freq_index, detect
    );
endinterface

// File: rtl/caf_freq_max_select.sv
// rtl/caf_freq_max_select.sv - picks the global CAF peak across one sweep of frequency bins
module caf_freq_max_select #(
    parameter int FREQ_BINS       = 8,
    parameter int FREQ_INDEX_BITS = 3,
    parameter int INDEX_BITS      = 4,
    parameter int MAX_BITS        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    caf_freq_max_select_if.slave bus
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [FREQ_INDEX_BITS-1:0] LAST_BIN = FREQ_INDEX_BITS'(FREQ_BINS - 1);
    localparam logic [FREQ_INDEX_BITS-1:0] ONE_BIN  = FREQ_INDEX_BITS'(1);

    state_t state;
    state_t state_next;

    logic [FREQ_INDEX_BITS-1:0] bin_cnt;
    logic [MAX_BITS-1:0]        run_max;
    logic [INDEX_BITS-1:0]      run_time;
    logic [FREQ_INDEX_BITS-1:0] run_freq;

    logic                       tready_r;
    logic                       tvalid_r;
    logic [MAX_BITS-1:0]        out_max_r;
    logic [INDEX_BITS-1:0]      time_index_r;
    logic [FREQ_INDEX_BITS-1:0] freq_index_r;
    logic                       detect_r;

    logic                       accept;
    logic                       take;
    logic                       last_bin;
    logic                       complete;
    logic                       release_hs;
    logic [MAX_BITS-1:0]        upd_max;
    logic [INDEX_BITS-1:0]      upd_time;
    logic [FREQ_INDEX_BITS-1:0] upd_freq;

    // Running-peak update for the current beat and sweep/handshake events
    always_comb begin
        accept     = bus.m_axis_tvalid & tready_r;
        // Bin 0 always seeds the running peak; later bins must be strictly larger so ties keep the earlier bin
        take       = accept & ((bin_cnt == '0) | (bus.in_max > run_max));
        upd_max    = take ? bus.in_max   : run_max;
        upd_time   = take ? bus.in_index : run_time;
        upd_freq   = take ? bin_cnt      : run_freq;
        last_bin   = (bin_cnt == LAST_BIN);
        complete   = accept & last_bin;
        release_hs = tvalid_r & bus.m_axis_tready;
    end

    // Next-state: accumulate until the last bin is taken, then hold until downstream takes the result
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (complete)   state_next = HOLD;
            HOLD:  if (release_hs) state_next = ACCUM;
            default:               state_next = ACCUM;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Running peak, bin counter and registered sweep result
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_cnt      <= '0;
            run_max      <= '0;
            run_time     <= '0;
            run_freq     <= '0;
            tready_r     <= 1'b0;
            tvalid_r     <= 1'b0;
            out_max_r    <= '0;
            time_index_r <= '0;
            freq_index_r <= '0;
            detect_r     <= 1'b0;
        end else begin
            // Ready only while accumulating, so input accept and output handshake never share a cycle
            tready_r <= (state_next == ACCUM);
            if (accept) begin
                run_max  <= upd_max;
                run_time <= upd_time;
                run_freq <= upd_freq;
                bin_cnt  <= last_bin ? '0 : bin_cnt + ONE_BIN;
            end
            if (complete) begin
                out_max_r    <= upd_max;
                time_index_r <= upd_time;
                freq_index_r <= upd_freq;
                detect_r     <= (upd_max >= bus.threshold);
                tvalid_r     <= 1'b1;
            end else if (release_hs) begin
                tvalid_r     <= 1'b0;
            end
        end
    end

    assign bus.s_axis_tready = tready_r;
    assign bus.s_axis_tvalid = tvalid_r;
    assign bus.out_max       = out_max_r;
    assign bus.time_index    = time_index_r;
    assign bus.freq_index    = freq_index_r;
    assign bus.detect        = detect_r;

endmodule
